// File: rtl/instruction_fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage_pkg
//   Shared definitions for the instruction fetch stage: fetch FSM state
//   encoding, the default reset fetch address, the NOP pattern placed in an
//   empty IF/ID slot, and the instruction word size in bytes.
// ----------------------------------------------------------------------------
package instruction_fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // one dead cycle after reset
      ST_REQ  = 2'd1,   // request presented to instruction memory
      ST_WAIT = 2'd2,   // request accepted, waiting for the response
      ST_HOLD = 2'd3    // response parked while ID is stalled
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;  // text-segment base
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
   localparam int unsigned WORD_BYTES        = 4;

endpackage : instruction_fetch_stage_pkg

// File: rtl/instruction_fetch_stage_ifid_register.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage_ifid_register
//   IF/ID pipeline register. Holds valid, pc, pc+4 and the instruction word.
//   Priority: reset > flush > load > consume > hold.
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   load              capture load_pc / load_instr as a valid entry
//   flush             empty the slot (valid=0, instr=NOP)
//   consume           ID took the entry; empty the slot unless loading
//   load_pc           address of the instruction being loaded
//   load_instr        instruction word being loaded
//   valid             slot holds a real instruction
//   pc, pc_plus4      address of instr and that address + 4 (wrapping)
//   instr             instruction word, NOP when the slot is empty
// ----------------------------------------------------------------------------
module instruction_fetch_stage_ifid_register
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned           ADDR_W    = 32,
   parameter int unsigned           DATA_W    = 32,
   parameter logic [DATA_W-1:0]     NOP_INSTR = DATA_W'(DEFAULT_NOP_INSTR)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              flush,
   input  logic              consume,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic [DATA_W-1:0] load_instr,
   output logic              valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [DATA_W-1:0] instr
);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid    <= 1'b0;
         pc       <= '0;
         pc_plus4 <= '0;
         instr    <= NOP_INSTR;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid    <= 1'b1;
         pc       <= load_pc;
         pc_plus4 <= load_pc + ADDR_W'(WORD_BYTES);  // wraps mod 2^ADDR_W
         instr    <= load_instr;
      end else if (consume) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end
   end

endmodule : instruction_fetch_stage_ifid_register

// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//   Fetch stage between the program counter and ID. Owns the fetch address,
//   keeps at most one instruction-memory request outstanding (valid/ready),
//   writes responses into the IF/ID register, and handles ID stall plus
//   branch/jump redirect with flush.
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   redirect_valid/pc   taken branch/jump (1-cycle pulse) and its target
//   id_stall            ID cannot accept; IF/ID holds its contents
//   imem_req_valid/addr request to instruction memory (addr 0 when idle)
//   imem_req_ready      memory accepts the request this cycle
//   imem_rsp_valid/data instruction response, >=1 cycle after accept
//   ifid_valid/pc/pc_plus4/instr   IF/ID pipeline register contents
//   fetch_misalign      1-cycle pulse after a redirect with pc[1:0] != 0
// ----------------------------------------------------------------------------
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEFAULT_NOP_INSTR)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              id_stall,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              ifid_valid,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic [ADDR_W-1:0] ifid_pc_plus4,
   output logic [DATA_W-1:0] ifid_instr,
   output logic              fetch_misalign
);

   fetch_state_t      state, state_next;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
   logic              kill, kill_next;            // drop the in-flight response
   logic              hold_valid, hold_valid_next;
   logic [ADDR_W-1:0] hold_pc, hold_pc_next;
   logic [DATA_W-1:0] hold_instr, hold_instr_next;

   logic              req_handshake;
   logic              slot_free;
   logic              ifid_load;
   logic [ADDR_W-1:0] ifid_load_pc;
   logic [DATA_W-1:0] ifid_load_instr;

   assign imem_req_valid = (state == ST_REQ);
   assign imem_req_addr  = imem_req_valid ? fetch_pc : '0;
   assign req_handshake  = imem_req_valid && imem_req_ready;
   assign slot_free      = !ifid_valid || !id_stall;

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_next      = state;
      fetch_pc_next   = fetch_pc;
      kill_next       = kill;
      hold_valid_next = hold_valid;
      hold_pc_next    = hold_pc;
      hold_instr_next = hold_instr;
      ifid_load       = 1'b0;
      ifid_load_pc    = fetch_pc;
      ifid_load_instr = imem_rsp_data;

      if (redirect_valid) begin
         // Redirect beats stall and any same-cycle response.
         fetch_pc_next   = {redirect_pc[ADDR_W-1:2], 2'b00};
         hold_valid_next = 1'b0;
         if ((state == ST_WAIT && !imem_rsp_valid) || req_handshake) begin
            // A stale request is still in flight: wait for it and throw it away.
            kill_next  = 1'b1;
            state_next = ST_WAIT;
         end else begin
            kill_next  = 1'b0;
            state_next = ST_REQ;
         end
      end else begin
         unique case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
               if (req_handshake) state_next = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  state_next = ST_REQ;
                  if (kill) begin
                     // fetch_pc already holds the redirect target.
                     kill_next = 1'b0;
                  end else if (slot_free) begin
                     ifid_load     = 1'b1;
                     fetch_pc_next = fetch_pc + ADDR_W'(WORD_BYTES);
                  end else begin
                     hold_valid_next = 1'b1;
                     hold_pc_next    = fetch_pc;
                     hold_instr_next = imem_rsp_data;
                     fetch_pc_next   = fetch_pc + ADDR_W'(WORD_BYTES);
                     state_next      = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!id_stall) begin
                  ifid_load       = 1'b1;
                  ifid_load_pc    = hold_pc;
                  ifid_load_instr = hold_instr;
                  hold_valid_next = 1'b0;
                  state_next      = ST_REQ;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         fetch_pc       <= RESET_PC;
         kill           <= 1'b0;
         hold_valid     <= 1'b0;
         fetch_misalign <= 1'b0;
      end else begin
         state          <= state_next;
         fetch_pc       <= fetch_pc_next;
         kill           <= kill_next;
         hold_valid     <= hold_valid_next;
         fetch_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end

   // NOTE: the hold buffer payload carries no reset; it is only ever read
   // while hold_valid is set, and hold_valid itself is reset.
   always_ff @(posedge clock) begin
      hold_pc    <= hold_pc_next;
      hold_instr <= hold_instr_next;
   end

   instruction_fetch_stage_ifid_register #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_register (
      .clock      (clock),
      .reset      (reset),
      .load       (ifid_load),
      .flush      (redirect_valid),
      .consume    (ifid_valid && !id_stall),
      .load_pc    (ifid_load_pc),
      .load_instr (ifid_load_instr),
      .valid      (ifid_valid),
      .pc         (ifid_pc),
      .pc_plus4   (ifid_pc_plus4),
      .instr      (ifid_instr)
   );

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//   Directed bench for instruction_fetch_stage. A zero-wait memory responder
//   lives inside cycle(): an accepted request is answered during the next
//   cycle with mem_word(addr). Directed steps may override the response to
//   delay it or inject a late one. Inputs change and outputs are sampled 1
//   time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

   logic        clock;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_stall;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
   logic [31:0] ifid_instr;
   logic        fetch_misalign;

   int checks = 0;
   int errors = 0;

   instruction_fetch_stage dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .ifid_instr     (ifid_instr),
      .fetch_misalign (fetch_misalign)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory contents: address xor a fixed pattern.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock. The handshake is sampled before the edge; the
   // response for an accepted request is driven for the following cycle.
   task automatic cycle();
      logic        hs;
      logic [31:0] addr;
      hs   = imem_req_valid && imem_req_ready;
      addr = imem_req_addr;
      @(posedge clock);
      #1;
      if (hs) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_stall       = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;

      // ---------------- reset state ----------------
      cycle();
      cycle();
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr",  imem_req_addr,       32'h0);
      check("rst_ifid_valid",32'(ifid_valid),     32'd0);
      check("rst_ifid_pc",   ifid_pc,             32'h0);
      check("rst_ifid_instr",ifid_instr,          32'h0);
      check("rst_misalign",  32'(fetch_misalign), 32'd0);
      reset = 1'b0;

      // ---------------- 1: two back-to-back fetches ----------------
      cycle();                                   // IDLE -> REQ
      check("t1_req0_valid", 32'(imem_req_valid), 32'd1);
      check("t1_req0_addr",  imem_req_addr,       32'h0040_0000);
      cycle();                                   // accepted -> WAIT
      check("t1_wait_valid", 32'(imem_req_valid), 32'd0);
      cycle();                                   // response lands in IF/ID
      check("t1_i0_valid",   32'(ifid_valid),     32'd1);
      check("t1_i0_pc",      ifid_pc,             32'h0040_0000);
      check("t1_i0_pc4",     ifid_pc_plus4,       32'h0040_0004);
      check("t1_i0_instr",   ifid_instr,          32'h1317_9BDF);
      check("t1_req1_addr",  imem_req_addr,       32'h0040_0004);
      cycle();                                   // I0 consumed, nothing new
      check("t1_consumed",   32'(ifid_valid),     32'd0);
      check("t1_nop",        ifid_instr,          32'h0);
      cycle();
      check("t1_i1_pc",      ifid_pc,             32'h0040_0004);
      check("t1_i1_pc4",     ifid_pc_plus4,       32'h0040_0008);
      check("t1_i1_instr",   ifid_instr,          32'h1317_9BDB);
      check("t1_req2_addr",  imem_req_addr,       32'h0040_0008);

      // ---------------- 3: stall while the response arrives ----------------
      id_stall = 1'b1;
      cycle();                                   // accept 0x0040_0008
      check("t3_keep_valid", 32'(ifid_valid),     32'd1);
      check("t3_keep_pc",    ifid_pc,             32'h0040_0004);
      cycle();                                   // response parked in HOLD
      check("t3_hold_req",   32'(imem_req_valid), 32'd0);
      check("t3_hold_pc",    ifid_pc,             32'h0040_0004);
      check("t3_hold_instr", ifid_instr,          32'h1317_9BDB);
      cycle();
      check("t3_hold2_req",  32'(imem_req_valid), 32'd0);
      id_stall = 1'b0;
      cycle();                                   // HOLD -> IF/ID, REQ
      check("t3_rel_valid",  32'(ifid_valid),     32'd1);
      check("t3_rel_pc",     ifid_pc,             32'h0040_0008);
      check("t3_rel_instr",  ifid_instr,          32'h1317_9BD7);
      check("t3_rel_req",    32'(imem_req_valid), 32'd1);
      check("t3_rel_addr",   imem_req_addr,       32'h0040_000C);

      // ---------------- 4: redirect during WAIT, response killed ----------------
      cycle();                                   // accept 0x0040_000C
      imem_rsp_valid = 1'b0;                     // memory is slow this time
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0100;
      cycle();
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b1;                     // stale response arrives now
      imem_rsp_data  = mem_word(32'h0040_000C);
      check("t4_flush_valid",32'(ifid_valid),     32'd0);
      check("t4_flush_nop",  ifid_instr,          32'h0);
      check("t4_wait_req",   32'(imem_req_valid), 32'd0);
      check("t4_no_misalign",32'(fetch_misalign), 32'd0);
      cycle();                                   // stale data discarded
      check("t4_killed",     32'(ifid_valid),     32'd0);
      check("t4_req_valid",  32'(imem_req_valid), 32'd1);
      check("t4_req_addr",   imem_req_addr,       32'h0040_0100);
      cycle();
      cycle();
      check("t4_tgt_valid",  32'(ifid_valid),     32'd1);
      check("t4_tgt_pc",     ifid_pc,             32'h0040_0100);
      check("t4_tgt_pc4",    ifid_pc_plus4,       32'h0040_0104);
      check("t4_tgt_instr",  ifid_instr,          32'h1317_9ADF);

      // ---------------- 5: misaligned redirect while REQ is stalled ----------------
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0102;
      cycle();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      check("t5_misalign",   32'(fetch_misalign), 32'd1);
      check("t5_req_addr",   imem_req_addr,       32'h0040_0100);
      check("t5_flush",      32'(ifid_valid),     32'd0);
      cycle();
      check("t5_pulse_end",  32'(fetch_misalign), 32'd0);
      cycle();
      check("t5_pc",         ifid_pc,             32'h0040_0100);

      // ---------------- 6: redirect with handshake, wrap, reset in WAIT ----------------
      redirect_valid = 1'b1;                     // REQ 0x0040_0104 accepted same cycle
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      check("t6_kill_wait",  32'(imem_req_valid), 32'd0);
      check("t6_flush",      32'(ifid_valid),     32'd0);
      cycle();                                   // response for 0x0040_0104 dropped
      check("t6_dropped",    32'(ifid_valid),     32'd0);
      check("t6_req_addr",   imem_req_addr,       32'hFFFF_FFFC);
      cycle();
      cycle();
      check("t6_wrap_pc",    ifid_pc,             32'hFFFF_FFFC);
      check("t6_wrap_pc4",   ifid_pc_plus4,       32'h0000_0000);
      check("t6_wrap_instr", ifid_instr,          32'hECA8_6423);
      check("t6_wrap_addr",  imem_req_addr,       32'h0000_0000);
      cycle();                                   // accept 0x0000_0000 -> WAIT
      imem_rsp_valid = 1'b0;
      reset          = 1'b1;
      cycle();
      reset          = 1'b0;
      imem_rsp_valid = 1'b1;                     // late response after reset
      imem_rsp_data  = mem_word(32'h0000_0000);
      check("t6_rst_req",    32'(imem_req_valid), 32'd0);
      check("t6_rst_ifid",   32'(ifid_valid),     32'd0);
      cycle();
      check("t6_late_ign",   32'(ifid_valid),     32'd0);
      check("t6_restart",    imem_req_addr,       32'h0040_0000);

      // ---------------- 2: memory not ready for 3 cycles ----------------
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t2_held_valid", 32'(imem_req_valid), 32'd1);
         check("t2_held_addr",  imem_req_addr,       32'h0040_0000);
      end
      imem_req_ready = 1'b1;
      cycle();
      check("t2_accepted",   32'(imem_req_valid), 32'd0);
      cycle();
      check("t2_ifid_pc",    ifid_pc,             32'h0040_0000);
      check("t2_ifid_instr", ifid_instr,          32'h1317_9BDF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_instruction_fetch_stage
